button_event_gen: RTL and testbench



---
 rtl/timer_pkg.sv | 23 ++
 rtl/btn_repeat_fsm.sv | 95 +++++++++
 rtl/button_event_gen.sv | 49 ++++
 tb/tb_button_event_gen.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer front-end: button FSM states,
// channel count, hold/repeat timing and a counter-width helper.
package timer_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE,
    BTN_PRESSED,
    BTN_REPEAT
  } btn_state_t;

  localparam int N_BTN_DEFAULT   = 5;
  localparam int HOLD_MS_DEFAULT = 500;
  localparam int RATE_MS_DEFAULT = 150;

  // Width of a millisecond counter large enough for both the hold and the
  // repeat thresholds, with one spare bit of headroom.
  function automatic int cnt_width(input int hold_ms, input int rate_ms);
    int m;
    m = (hold_ms > rate_ms) ? hold_ms : rate_ms;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/btn_repeat_fsm.sv
// One button channel: turns a press edge into a single registered pulse and,
// when repeat is enabled, keeps pulsing on the millisecond tick while held.
module btn_repeat_fsm
  import timer_pkg::*;
#(
  parameter bit REPEAT_EN = 1'b1,
  parameter int HOLD_MS   = HOLD_MS_DEFAULT,
  parameter int RATE_MS   = RATE_MS_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_i,
  input  logic level_i,
  input  logic press_i,
  output logic pulse_o,
  output logic repeating_o
);

  localparam int CW = cnt_width(HOLD_MS, RATE_MS);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MS - 1);
  localparam logic [CW-1:0] RATE_LAST = CW'(RATE_MS - 1);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  if (HOLD_MS < 1 || RATE_MS < 1) begin : g_bad_timing
    $error("btn_repeat_fsm: HOLD_MS and RATE_MS must both be at least 1");
  end

  btn_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pulse_q, pulse_d;

  // State, counter and pulse registers; reset drops the channel back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BTN_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  // Next state: release wins over everything, otherwise count ticks toward the hold/repeat thresholds.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (!level_i) begin
      state_d = BTN_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        BTN_IDLE: begin
          if (press_i) begin
            state_d = BTN_PRESSED;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end
        end
        BTN_PRESSED: begin
          if (REPEAT_EN && tick_i) begin
            if (cnt_q == HOLD_LAST) begin
              state_d = BTN_REPEAT;
              cnt_d   = '0;
              pulse_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        BTN_REPEAT: begin
          if (tick_i) begin
            if (cnt_q == RATE_LAST) begin
              cnt_d   = '0;
              pulse_d = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = BTN_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign pulse_o     = pulse_q;
  assign repeating_o = (state_q == BTN_REPEAT);

endmodule

// File: rtl/button_event_gen.sv
// Converts debounced button levels into one-clock command pulses, with
// optional auto-repeat per channel while a button is held.
module button_event_gen
  import timer_pkg::*;
#(
  parameter int                N_BTN       = N_BTN_DEFAULT,
  parameter logic [N_BTN-1:0]  REPEAT_MASK = N_BTN'(5'b00011),
  parameter int                HOLD_MS     = HOLD_MS_DEFAULT,
  parameter int                RATE_MS     = RATE_MS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1ms,
  input  logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_repeating
);

  logic [N_BTN-1:0] prev_q;
  logic [N_BTN-1:0] press;

  // Edge history resets to all ones so a button held through reset never fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '1;
    end else begin
      prev_q <= btn_level;
    end
  end

  assign press = btn_level & ~prev_q;

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_repeat_fsm #(
      .REPEAT_EN (REPEAT_MASK[g]),
      .HOLD_MS   (HOLD_MS),
      .RATE_MS   (RATE_MS)
    ) u_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick_i      (tick_1ms),
      .level_i     (btn_level[g]),
      .press_i     (press[g]),
      .pulse_o     (btn_pulse[g]),
      .repeating_o (btn_repeating[g])
    );
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with short hold/repeat timing
// (HOLD_MS=5, RATE_MS=2, a tick every 10 clocks).
module tb_button_event_gen;

  logic       clk;
  logic       rst_n;
  logic       tick_1ms;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;
  logic [4:0] btn_repeating;

  int checkCount;
  int errorCount;

  button_event_gen #(
    .N_BTN       (5),
    .REPEAT_MASK (5'b00011),
    .HOLD_MS     (5),
    .RATE_MS     (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_1ms      (tick_1ms),
    .btn_level     (btn_level),
    .btn_pulse     (btn_pulse),
    .btn_repeating (btn_repeating)
  );

  // 100 MHz system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value and count it
  task automatic checkOutput(input string tag, input logic [4:0] observed,
                             input logic [4:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Drive tick and levels for one clock, then settle 1 ns past the edge
  task automatic applyStimulus(input logic tick, input logic [4:0] level);
    tick_1ms  = tick;
    btn_level = level;
    @(posedge clk);
    #1;
  endtask

  // Directed test sequence
  initial begin
    logic [4:0] expPulse;
    logic [4:0] expRep;
    checkCount = 0;
    errorCount = 0;
    rst_n      = 1'b0;
    tick_1ms   = 1'b0;
    btn_level  = 5'b00000;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_pulse", btn_pulse, 5'b00000);
    checkOutput("reset_repeating", btn_repeating, 5'b00000);
    rst_n = 1'b1;
    applyStimulus(1'b0, 5'b00000);
    applyStimulus(1'b0, 5'b00000);
    checkOutput("idle_pulse", btn_pulse, 5'b00000);

    // Start button: one pulse at the press, no repeat, tick in press cycle ignored
    $display("[TB] start button single pulse");
    for (int c = 0; c < 200; c++) begin
      applyStimulus(c % 10 == 0, 5'b10000);
      expPulse = (c == 0) ? 5'b10000 : 5'b00000;
      checkOutput($sformatf("start_pulse_c%0d", c), btn_pulse, expPulse);
      checkOutput($sformatf("start_rep_c%0d", c), btn_repeating, 5'b00000);
    end
    applyStimulus(1'b0, 5'b00000);
    checkOutput("start_release", btn_pulse, 5'b00000);
    applyStimulus(1'b0, 5'b00000);

    // inc_sec held: pulses at 0, 50 (5 counted ticks), then every 20 clk; release on a threshold tick at 130
    $display("[TB] inc_sec auto repeat");
    for (int c = 0; c <= 130; c++) begin
      applyStimulus(c % 10 == 0, (c < 130) ? 5'b00001 : 5'b00000);
      expPulse = (c == 0 || c == 50 || c == 70 || c == 90 || c == 110) ? 5'b00001 : 5'b00000;
      expRep   = (c >= 50 && c < 130) ? 5'b00001 : 5'b00000;
      checkOutput($sformatf("rep_pulse_c%0d", c), btn_pulse, expPulse);
      checkOutput($sformatf("rep_state_c%0d", c), btn_repeating, expRep);
    end
    applyStimulus(1'b0, 5'b00000);

    // Release exactly on the hold threshold tick: no repeat pulse
    $display("[TB] release on hold threshold");
    for (int c = 0; c <= 50; c++) begin
      applyStimulus(c % 10 == 0, (c < 50) ? 5'b00001 : 5'b00000);
      expPulse = (c == 0) ? 5'b00001 : 5'b00000;
      checkOutput($sformatf("holdrel_pulse_c%0d", c), btn_pulse, expPulse);
      checkOutput($sformatf("holdrel_rep_c%0d", c), btn_repeating, 5'b00000);
    end
    applyStimulus(1'b0, 5'b00000);

    // inc_min held through a reset: nothing fires until released and pressed again
    $display("[TB] hold through reset");
    applyStimulus(1'b0, 5'b00010);
    checkOutput("hold_rst_first_press", btn_pulse, 5'b00010);
    rst_n = 1'b0;
    #1;
    checkOutput("hold_rst_async_clear", btn_pulse, 5'b00000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      applyStimulus(c % 10 == 0, 5'b00010);
      checkOutput($sformatf("hold_rst_pulse_c%0d", c), btn_pulse, 5'b00000);
      checkOutput($sformatf("hold_rst_rep_c%0d", c), btn_repeating, 5'b00000);
    end
    applyStimulus(1'b0, 5'b00000);
    checkOutput("hold_rst_release", btn_pulse, 5'b00000);
    applyStimulus(1'b0, 5'b00010);
    checkOutput("hold_rst_repress", btn_pulse, 5'b00010);
    applyStimulus(1'b0, 5'b00010);
    checkOutput("hold_rst_repress_after", btn_pulse, 5'b00000);
    applyStimulus(1'b0, 5'b00000);

    // Three channels pressed together pulse together
    $display("[TB] simultaneous presses");
    applyStimulus(1'b0, 5'b10101);
    checkOutput("multi_press", btn_pulse, 5'b10101);
    applyStimulus(1'b0, 5'b10101);
    checkOutput("multi_press_after", btn_pulse, 5'b00000);
    applyStimulus(1'b0, 5'b00000);
    applyStimulus(1'b0, 5'b00000);

    // Reset while repeating: outputs drop immediately and the channel stays idle
    $display("[TB] reset during repeat");
    for (int c = 0; c <= 50; c++) begin
      applyStimulus(c % 10 == 0, 5'b00001);
    end
    checkOutput("rst_rep_pre_pulse", btn_pulse, 5'b00001);
    checkOutput("rst_rep_pre_state", btn_repeating, 5'b00001);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rep_async_pulse", btn_pulse, 5'b00000);
    checkOutput("rst_rep_async_state", btn_repeating, 5'b00000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 60; c++) begin
      applyStimulus(c % 10 == 0, 5'b00001);
      checkOutput($sformatf("rst_rep_after_pulse_c%0d", c), btn_pulse, 5'b00000);
      checkOutput($sformatf("rst_rep_after_state_c%0d", c), btn_repeating, 5'b00000);
    end
    applyStimulus(1'b0, 5'b00000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
